switch_char_entry: RTL and testbench

SWITCH_CHAR_ENTRY -- requirements
Module: switch_char_entry

---
 rtl/switch_char_entry.sv | 218 +++++++++++++++++++++
 tb/tb_switch_char_entry.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_char_entry.sv
// -----------------------------------------------------------------------------
// switch_char_entry
//   Character entry front end: a bank of switches supplies a character value,
//   a bouncy confirm button enters it into a small show-ahead FIFO and a bouncy
//   delete button removes the newest unread character.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low reset
//   switches       : raw character value (DATA_W bits)
//   confirm_button : raw push button, a debounced press enters a character
//   delete_button  : raw push button, a debounced press removes the newest one
//   out_data       : oldest buffered character (0 while nothing is buffered)
//   out_valid      : out_data holds a buffered character
//   out_ready      : consumer accepts out_data when out_valid is 1
//   count          : number of buffered characters, 0..DEPTH
//   full / empty   : count==DEPTH / count==0
//   overflow       : sticky, set when a confirm is dropped on a full buffer
// -----------------------------------------------------------------------------
module switch_char_entry #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        switches,
  input  logic                     confirm_button,
  input  logic                     delete_button,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is confirm, index 1 is delete.
  logic [DATA_W-1:0] r_sw_s1;
  logic [DATA_W-1:0] r_sw_s2;
  logic [1:0]        r_btn_s1;
  logic [1:0]        r_btn_s2;
  logic [1:0]        r_warm;
  logic [DBW-1:0]    r_db_cnt [2];
  logic [1:0]        r_db_lvl;
  logic [1:0]        r_db_prev;
  logic [1:0]        r_armed;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;

  logic [1:0]        w_evt;
  logic              w_pop;
  logic              w_del;
  logic              w_push;
  logic              w_ovf_set;
  logic [AW-1:0]     w_head_n;
  logic [AW-1:0]     w_tail_n;
  logic [CW-1:0]     w_cnt_n;
  logic [DATA_W-1:0] w_data_n;

  // Two-flop synchronizers for all raw inputs, plus a warm-up marker that
  // tells when the synchronizer outputs reflect post-reset input levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= 2'b00;
      r_btn_s2 <= 2'b00;
      r_warm   <= 2'b00;
    end else begin
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= {delete_button, confirm_button};
      r_btn_s2 <= r_btn_s1;
      r_warm   <= {r_warm[0], 1'b1};
    end
  end

  // Per-button debouncer and arming. A button is armed only after it has been
  // seen released once reset is over, so a button held through reset release
  // cannot produce a press event until it is released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_db_lvl  <= 2'b00;
      r_db_prev <= 2'b00;
      r_armed   <= 2'b00;
    end else begin
      r_db_prev <= r_db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] != r_db_lvl[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_lvl[i] <= r_btn_s2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
        if (r_warm[1] && !r_btn_s2[i]) begin
          r_armed[i] <= 1'b1;
        end
      end
    end
  end

  // Single-cycle press events on a debounced rising edge.
  assign w_evt = r_db_lvl & ~r_db_prev & r_armed;

  // FIFO control: delete beats confirm, a pop beats a delete of the last entry.
  always_comb begin
    w_pop     = r_out_valid & out_ready;
    w_del     = 1'b0;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_head_n  = r_head;
    w_tail_n  = r_tail;
    w_data_n  = '0;

    if (w_evt[1] && !r_empty && !((r_count == CW'(1)) && w_pop)) begin
      w_del = 1'b1;
    end else begin
      w_del = 1'b0;
    end

    if (w_evt[0] && !w_del) begin
      if (!r_full || w_pop) begin
        w_push = 1'b1;
      end else begin
        w_ovf_set = 1'b1;
      end
    end else begin
      w_push    = 1'b0;
      w_ovf_set = 1'b0;
    end

    if (w_pop) begin
      w_head_n = r_head + AW'(1);
    end else begin
      w_head_n = r_head;
    end

    case ({w_push, w_del})
      2'b10:   w_tail_n = r_tail + AW'(1);
      2'b01:   w_tail_n = r_tail - AW'(1);
      default: w_tail_n = r_tail;
    endcase

    w_cnt_n = r_count + CW'(w_push) - CW'(w_pop) - CW'(w_del);

    // The slot at the tail is free unless the buffer is full, and a push on a
    // full buffer always comes with a pop, so a write landing on the next head
    // slot is the character that must be shown next.
    if (w_cnt_n == '0) begin
      w_data_n = '0;
    end else if (w_push && (r_tail == w_head_n)) begin
      w_data_n = r_sw_s2;
    end else begin
      w_data_n = r_mem[w_head_n];
    end
  end

  // Character storage; contents are meaningless outside head..tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= r_sw_s2;
    end
  end

  // Pointers, occupancy and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      r_head      <= w_head_n;
      r_tail      <= w_tail_n;
      r_count     <= w_cnt_n;
      r_out_data  <= w_data_n;
      r_out_valid <= (w_cnt_n != '0);
      r_full      <= (w_cnt_n == DEPTH_C);
      r_empty     <= (w_cnt_n == '0);
      r_overflow  <= r_overflow | w_ovf_set;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_switch_char_entry.sv
// -----------------------------------------------------------------------------
// tb_switch_char_entry
//   Directed bench for switch_char_entry (DATA_W=8, DEPTH=4, DEBOUNCE_CYCLES=4).
//   Stimulus pushes expected characters into a queue; a monitor pops and
//   compares whenever the DUT hands out a character (out_valid && out_ready).
// -----------------------------------------------------------------------------
module tb_switch_char_entry;

  logic       clk;
  logic       reset;
  logic [7:0] switches;
  logic       confirm_button;
  logic       delete_button;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];

  switch_char_entry #(
    .DATA_W(8),
    .DEPTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches(switches),
    .confirm_button(confirm_button),
    .delete_button(delete_button),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press-and-release of one button (0 = confirm, 1 = delete).
  task automatic press(input int which, input logic [7:0] val);
    switches = val;
    if (which == 0) confirm_button = 1'b1;
    else            delete_button  = 1'b1;
    wait_neg(8);
    confirm_button = 1'b0;
    delete_button  = 1'b0;
    wait_neg(8);
  endtask

  task automatic drain(input int cycles);
    out_ready = 1'b1;
    wait_neg(cycles);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},    32'(count),     32'd0);
    chk({tag, "_empty"},    32'(empty),     32'd1);
    chk({tag, "_full"},     32'(full),      32'd0);
    chk({tag, "_valid"},    32'(out_valid), 32'd0);
    chk({tag, "_data"},     32'(out_data),  32'd0);
    chk({tag, "_overflow"}, 32'(overflow),  32'd0);
  endtask

  // Scoreboard monitor: sampled 2 ns after the falling edge, well clear of
  // both the driving edge and the active rising edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got %0h expected no data", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 32'(out_data), 32'(e));
        end
      end
    end
  end

  initial begin
    reset          = 1'b0;
    switches       = 8'h00;
    confirm_button = 1'b0;
    delete_button  = 1'b0;
    out_ready      = 1'b0;
    wait_neg(3);
    chk_reset_outputs("rst");
    reset = 1'b1;
    wait_neg(4);

    // Clean confirm press: event 6 cycles after the press, visible one later.
    switches       = 8'h41;
    confirm_button = 1'b1;
    exp_q.push_back(8'h41);
    wait_neg(6);
    chk("press_latency_valid", 32'(out_valid), 32'd0);
    wait_neg(1);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data",  32'(out_data),  32'h41);
    chk("first_count", 32'(count),     32'd1);
    wait_neg(1);
    confirm_button = 1'b0;
    wait_neg(8);
    chk("hold_no_repeat", 32'(count), 32'd1);
    drain(3);
    chk("first_drained_empty", 32'(empty), 32'd1);

    // Bouncing confirm: exactly one entry, 4 stable cycles after last bounce.
    switches       = 8'h42;
    confirm_button = 1'b1;
    wait_neg(1); confirm_button = 1'b0;
    wait_neg(1); confirm_button = 1'b1;
    wait_neg(1); confirm_button = 1'b0;
    wait_neg(1); confirm_button = 1'b1;
    exp_q.push_back(8'h42);
    wait_neg(6);
    chk("bounce_before", 32'(count), 32'd0);
    wait_neg(1);
    chk("bounce_after", 32'(count), 32'd1);
    wait_neg(4);
    confirm_button = 1'b0;
    wait_neg(10);
    chk("bounce_single", 32'(count), 32'd1);
    drain(3);

    // Overflow on the fifth confirm, then FIFO order on drain.
    press(0, 8'h31); exp_q.push_back(8'h31);
    press(0, 8'h32); exp_q.push_back(8'h32);
    press(0, 8'h33); exp_q.push_back(8'h33);
    press(0, 8'h34); exp_q.push_back(8'h34);
    chk("fill_overflow_clear", 32'(overflow), 32'd0);
    press(0, 8'h35);
    chk("ovf_full",     32'(full),     32'd1);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_count",    32'(count),    32'd4);
    chk("ovf_head",     32'(out_data), 32'h31);
    drain(8);
    chk("ovf_drained_count", 32'(count),    32'd0);
    chk("ovf_sticky",        32'(overflow), 32'd1);

    // Delete removes the newest unread character.
    press(0, 8'h61); exp_q.push_back(8'h61);
    press(0, 8'h62); exp_q.push_back(8'h62);
    chk("del_pre_count", 32'(count), 32'd2);
    press(1, 8'h00); void'(exp_q.pop_back());
    chk("del_count", 32'(count),    32'd1);
    chk("del_head",  32'(out_data), 32'h61);
    drain(4);
    chk("del_final_count", 32'(count), 32'd0);
    chk("del_final_empty", 32'(empty), 32'd1);

    // Fresh reset, then push and pop in the same cycle on a full buffer.
    wait_neg(1);
    reset = 1'b0;
    wait_neg(2);
    reset = 1'b1;
    wait_neg(4);
    chk("rst2_overflow", 32'(overflow), 32'd0);
    press(0, 8'h51); exp_q.push_back(8'h51);
    press(0, 8'h52); exp_q.push_back(8'h52);
    press(0, 8'h53); exp_q.push_back(8'h53);
    press(0, 8'h54); exp_q.push_back(8'h54);
    chk("pp_full", 32'(full), 32'd1);
    switches       = 8'h39;
    confirm_button = 1'b1;
    exp_q.push_back(8'h39);
    wait_neg(6);
    out_ready = 1'b1;
    wait_neg(1);
    out_ready = 1'b0;
    chk("pp_count",    32'(count),    32'd4);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_head",     32'(out_data), 32'h52);
    wait_neg(1);
    confirm_button = 1'b0;
    wait_neg(8);
    drain(8);
    chk("pp_drained_empty", 32'(empty), 32'd1);

    // Reset with three entries buffered and a confirm mid-debounce.
    press(0, 8'h71);
    press(0, 8'h72);
    press(0, 8'h73);
    chk("rd_pre_count", 32'(count), 32'd3);
    switches       = 8'h74;
    confirm_button = 1'b1;
    wait_neg(4);
    reset = 1'b0;
    #1;
    chk_reset_outputs("rd");
    exp_q.delete();
    wait_neg(3);
    reset = 1'b1;
    wait_neg(12);
    chk("rd_held_no_event", 32'(count),     32'd0);
    chk("rd_held_no_valid", 32'(out_valid), 32'd0);
    confirm_button = 1'b0;
    wait_neg(10);
    chk("rd_release_no_event", 32'(count), 32'd0);
    press(0, 8'h75); exp_q.push_back(8'h75);
    chk("rd_fresh_count", 32'(count),    32'd1);
    chk("rd_fresh_data",  32'(out_data), 32'h75);
    drain(3);
    chk("rd_final_empty", 32'(empty), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    wait_neg(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
